div32_seq: RTL and testbench



---
 rtl/div32_seq_if.sv | 21 ++
 rtl/div32_seq.sv | 149 ++++++++++++++
 tb/tb_div32_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div32_seq_if.sv
// Handshake and data bundle between the control unit and the sequential signed divider.
interface div32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] RA;
    logic [WIDTH-1:0] RB;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] ZLow;
    logic [WIDTH-1:0] ZHigh;

    modport master (
        output start, RA, RB,
        input  busy, done, div_by_zero, ZLow, ZHigh
    );

    modport slave (
        input  start, RA, RB,
        output busy, done, div_by_zero, ZLow, ZHigh
    );
endinterface

// File: rtl/div32_seq.sv
// Multi-cycle signed 32-bit restoring divider: one trial subtraction per cycle,
// quotient to ZLow and remainder to ZHigh, with a divide-by-zero shortcut.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        clear,
    div32_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [4:0]       count_q, count_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] zlow_q, zlow_d;
    logic [WIDTH-1:0] zhigh_q, zhigh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   trial_s;

    // Next-state, datapath step and registered-output computation.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        p_d        = p_q;
        count_d    = count_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        zero_d     = zero_q;
        dbz_d      = dbz_q;
        zlow_d     = zlow_q;
        zhigh_d    = zhigh_q;
        trial_s    = {p_q[WIDTH-1:0], dividend_q[WIDTH-1]} - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.RB == {WIDTH{1'b0}}) begin
                        // Results are final immediately; FIX only adds the
                        // one cycle of latency before the done pulse.
                        dbz_d   = 1'b1;
                        zlow_d  = {WIDTH{1'b1}};
                        zhigh_d = bus.RA;
                        zero_d  = 1'b1;
                        state_d = FIX;
                    end else begin
                        sign_q_d   = bus.RA[WIDTH-1] ^ bus.RB[WIDTH-1];
                        sign_r_d   = bus.RA[WIDTH-1];
                        dividend_d = bus.RA[WIDTH-1] ? ({WIDTH{1'b0}} - bus.RA) : bus.RA;
                        divisor_d  = bus.RB[WIDTH-1] ? ({WIDTH{1'b0}} - bus.RB) : bus.RB;
                        p_d        = {(WIDTH+1){1'b0}};
                        count_d    = 5'd0;
                        zero_d     = 1'b0;
                        state_d    = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (!trial_s[WIDTH]) begin
                    p_d        = trial_s;
                    dividend_d = {dividend_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d        = {p_q[WIDTH-1:0], dividend_q[WIDTH-1]};
                    dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end
            FIX: begin
                if (!zero_q) begin
                    zlow_d  = sign_q_q ? ({WIDTH{1'b0}} - dividend_q) : dividend_q;
                    zhigh_d = sign_r_q ? ({WIDTH{1'b0}} - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    dbz_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DIV) || ((state_d == FIX) && !zero_d);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            dividend_q <= {WIDTH{1'b0}};
            divisor_q  <= {WIDTH{1'b0}};
            p_q        <= {(WIDTH+1){1'b0}};
            count_q    <= 5'd0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            zero_q     <= 1'b0;
            dbz_q      <= 1'b0;
            zlow_q     <= {WIDTH{1'b0}};
            zhigh_q    <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            p_q        <= p_d;
            count_q    <= count_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            zero_q     <= zero_d;
            dbz_q      <= dbz_d;
            zlow_q     <= zlow_d;
            zhigh_q    <= zhigh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.ZLow        = zlow_q;
    assign bus.ZHigh       = zhigh_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: latency, signed results,
// divide-by-zero, ignored start, abort by clear.
module tb_div32_seq;
    logic clock;
    logic clear;
    int   n_cmp;
    int   n_err;

    div32_seq_if #(.WIDTH(32)) bus ();

    div32_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse start for one cycle; returns at the negedge just after the sampling edge E0.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.RA    = a;
        bus.RB    = b;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.RA    = 32'hDEAD_BEEF;
        bus.RB    = 32'h0000_0001;
    endtask

    // Counts edges after E0 until done; lat = k means done is visible after E<k>.
    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy && bus.done) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s busy_and_done: got busy=1 done=1 required not both", name);
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clock);
        end
        n_cmp++;
        if (lat < 0) begin
            n_err++;
            $display("FAIL %s timeout: got no done required done within 100 cycles", name);
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dbz, input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        pulse_start(a, b);
        wait_done(name, lat, bc);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (bc !== exp_busy) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, exp_busy);
        end
        n_cmp++;
        if (bus.ZLow !== exp_q) begin
            n_err++;
            $display("FAIL %s ZLow: got %h required %h", name, bus.ZLow, exp_q);
        end
        n_cmp++;
        if (bus.ZHigh !== exp_r) begin
            n_err++;
            $display("FAIL %s ZHigh: got %h required %h", name, bus.ZHigh, exp_r);
        end
        n_cmp++;
        if (bus.div_by_zero !== exp_dbz) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %b required %b", name, bus.div_by_zero, exp_dbz);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.ZLow !== exp_q || bus.ZHigh !== exp_r) begin
            n_err++;
            $display("FAIL %s after_done: got done=%b q=%h r=%h required done=0 q=%h r=%h",
                     name, bus.done, bus.ZLow, bus.ZHigh, exp_q, exp_r);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.RA    = 32'h0;
        bus.RB    = 32'h0;
        clear     = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.ZLow !== 32'h0 || bus.ZHigh !== 32'h0) begin
            n_err++;
            $display("FAIL reset: got busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.ZLow, bus.ZHigh);
        end
    endtask

    task automatic test_signed();
        run_div("pos_pos",  32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 33);
        run_div("neg_pos",  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33, 33);
        run_div("pos_neg",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33, 33);
        run_div("neg_neg",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33, 33);
        run_div("overflow", 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33, 33);
    endtask

    task automatic test_div_by_zero();
        run_div("div_zero",   32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
        run_div("after_zero", 32'd9, 32'd3, 32'd3,         32'd0, 1'b0, 33, 33);
    endtask

    task automatic test_ignored_start();
        int lat;
        int bc;
        pulse_start(32'd1000, 32'd3);
        repeat (4) @(negedge clock);
        bus.RA    = 32'd50;
        bus.RB    = 32'd5;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done("ignored_start", lat, bc);
        n_cmp++;
        if (lat !== 28) begin
            n_err++;
            $display("FAIL ignored_start latency: got %0d required 28", lat);
        end
        n_cmp++;
        if (bus.ZLow !== 32'd333 || bus.ZHigh !== 32'd1) begin
            n_err++;
            $display("FAIL ignored_start result: got q=%0d r=%0d required q=333 r=1", bus.ZLow, bus.ZHigh);
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        int dones;
        pulse_start(32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.ZLow !== 32'h0 || bus.ZHigh !== 32'h0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.ZLow, bus.ZHigh);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) dones++;
            @(negedge clock);
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d busy/done cycles required 0", dones);
        end
        run_div("restart", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, 33);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear = 1'b0;
        test_reset();
        test_signed();
        test_div_by_zero();
        test_ignored_start();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
